// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared pipeline constants for the ID/EX stage:
//   - ALUC_*      : 4-bit ALU operation codes presented on alu_op
//   - SRC_A_*     : ALU A operand selector values
//   - src_b_e     : ALU B operand selector values
//   - REG_ZERO    : architectural zero register index
//   - upd_e       : how the ID/EX register is updated on a clock edge
//   - rt_is_used  : whether an instruction in ID actually reads rt
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam logic [3:0] ALUC_ADD  = 4'd0;
    localparam logic [3:0] ALUC_SUB  = 4'd1;
    localparam logic [3:0] ALUC_AND  = 4'd2;
    localparam logic [3:0] ALUC_OR   = 4'd3;
    localparam logic [3:0] ALUC_XOR  = 4'd4;
    localparam logic [3:0] ALUC_NOR  = 4'd5;
    localparam logic [3:0] ALUC_SLT  = 4'd6;
    localparam logic [3:0] ALUC_SLTU = 4'd7;
    localparam logic [3:0] ALUC_SLL  = 4'd8;
    localparam logic [3:0] ALUC_SRL  = 4'd9;
    localparam logic [3:0] ALUC_SRA  = 4'd10;
    localparam logic [3:0] ALUC_LUI  = 4'd11;

    localparam logic SRC_A_RS    = 1'b0;
    localparam logic SRC_A_SHAMT = 1'b1;

    typedef enum logic [1:0] {
        SRC_B_RT   = 2'd0,
        SRC_B_SIMM = 2'd1,
        SRC_B_ZIMM = 2'd2,
        SRC_B_RSVD = 2'd3
    } src_b_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        UPD_KEEP   = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_LOAD   = 2'd2
    } upd_e;

    // rt is a real source when B takes the register or the instruction stores rt.
    function automatic logic rt_is_used(input logic [1:0] src_b, input logic mem_write);
        return (src_b == SRC_B_RT) || mem_write;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// id_ex_stage_fwd_mux
// Resolves one source operand against the in-flight MEM and WB writes.
// Ports:
//   src                         : source register index held in EX
//   reg_data                    : register file data captured with it
//   mem_reg_write/mem_dst/mem_result : MEM-stage write port
//   wb_reg_write/wb_dst/wb_result    : WB-stage write port
//   fwd                         : operand value after forwarding
// MEM is younger than WB, so it wins. Register 0 never forwards.
// -----------------------------------------------------------------------------
module id_ex_stage_fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_data,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_dst,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] fwd
);

    logic mem_hit_s;
    logic wb_hit_s;

    assign mem_hit_s = mem_reg_write && (mem_dst != {RW{1'b0}}) && (mem_dst == src);
    assign wb_hit_s  = wb_reg_write  && (wb_dst  != {RW{1'b0}}) && (wb_dst  == src);

    // Priority select: MEM, then WB, then the captured register data.
    always_comb begin
        fwd = reg_data;
        if (mem_hit_s) begin
            fwd = mem_result;
        end else if (wb_hit_s) begin
            fwd = wb_result;
        end else begin
            fwd = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with EX-side operand selection feeding the ALU.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_*                : decoded instruction from ID
//   hold                : freeze the register
//   flush               : kill the instruction entering EX
//   mem_*/wb_*          : later-stage write ports used for forwarding
//   load_use_stall      : ID/IF must hold this cycle (combinational)
//   alu_a, alu_b, alu_op: ALU operands and operation
//   ex_*                : registered control, destination, PC, store data
// Update priority on each edge: flush > hold > load-use bubble > load.
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [15:0]   id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_op,
    input  logic          id_src_a,
    input  logic [1:0]    id_src_b,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          hold,
    input  logic          flush,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_dst,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_result,
    output logic          load_use_stall,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic [RW-1:0] ex_dst,
    output logic [DW-1:0] ex_store_data,
    output logic [DW-1:0] ex_pc
);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic [RW-1:0] dst;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [15:0]   imm;
        logic [4:0]    shamt;
        logic [3:0]    alu_op;
        logic          src_a;
        src_b_e        src_b;
    } ex_regs_t;

    ex_regs_t      ex_r;
    ex_regs_t      ex_d_s;
    upd_e          upd_s;
    logic          stall_s;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic [DW-1:0] alu_a_s;
    logic [DW-1:0] alu_b_s;

    // Load-use hazard: the load in EX produces data the ID instruction needs now.
    always_comb begin
        stall_s = 1'b0;
        if (ex_r.valid && ex_r.mem_read && (ex_r.dst != {RW{1'b0}}) && id_valid && !flush) begin
            if (ex_r.dst == id_rs) begin
                stall_s = 1'b1;
            end else if ((ex_r.dst == id_rt) && rt_is_used(id_src_b, id_mem_write)) begin
                stall_s = 1'b1;
            end else begin
                stall_s = 1'b0;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    assign load_use_stall = stall_s;

    // Choose how the register updates this edge (flush overrides hold).
    always_comb begin
        upd_s = UPD_LOAD;
        if (flush) begin
            upd_s = UPD_BUBBLE;
        end else if (hold) begin
            upd_s = UPD_KEEP;
        end else if (stall_s) begin
            upd_s = UPD_BUBBLE;
        end else begin
            upd_s = UPD_LOAD;
        end
    end

    // Next register contents; a bubble is all-zero so it can never write anything.
    always_comb begin
        ex_d_s = ex_r;
        case (upd_s)
            UPD_BUBBLE: ex_d_s = '0;
            UPD_LOAD: begin
                ex_d_s.valid      = id_valid;
                ex_d_s.reg_write  = id_reg_write;
                ex_d_s.mem_read   = id_mem_read;
                ex_d_s.mem_write  = id_mem_write;
                ex_d_s.mem_to_reg = id_mem_to_reg;
                ex_d_s.dst        = id_rd;
                ex_d_s.rs         = id_rs;
                ex_d_s.rt         = id_rt;
                ex_d_s.pc         = id_pc;
                ex_d_s.rs_data    = id_rs_data;
                ex_d_s.rt_data    = id_rt_data;
                ex_d_s.imm        = id_imm;
                ex_d_s.shamt      = id_shamt;
                ex_d_s.alu_op     = id_alu_op;
                ex_d_s.src_a      = id_src_a;
                ex_d_s.src_b      = src_b_e'(id_src_b);
            end
            UPD_KEEP: ex_d_s = ex_r;
            default:  ex_d_s = ex_r;
        endcase
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= '0;
        end else begin
            ex_r <= ex_d_s;
        end
    end

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src           (ex_r.rs),
        .reg_data      (ex_r.rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_result     (wb_result),
        .fwd           (fwd_rs_s)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src           (ex_r.rt),
        .reg_data      (ex_r.rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_result     (wb_result),
        .fwd           (fwd_rt_s)
    );

    // ALU A: forwarded rs or the zero-extended shift amount.
    always_comb begin
        alu_a_s = fwd_rs_s;
        if (ex_r.src_a == SRC_A_SHAMT) begin
            alu_a_s = {{(DW-5){1'b0}}, ex_r.shamt};
        end else begin
            alu_a_s = fwd_rs_s;
        end
    end

    // ALU B: forwarded rt or an extended immediate; the reserved code behaves as rt.
    always_comb begin
        alu_b_s = fwd_rt_s;
        case (ex_r.src_b)
            SRC_B_RT:   alu_b_s = fwd_rt_s;
            SRC_B_SIMM: alu_b_s = {{(DW-16){ex_r.imm[15]}}, ex_r.imm};
            SRC_B_ZIMM: alu_b_s = {{(DW-16){1'b0}}, ex_r.imm};
            SRC_B_RSVD: alu_b_s = fwd_rt_s;
            default:    alu_b_s = fwd_rt_s;
        endcase
    end

    assign alu_a         = alu_a_s;
    assign alu_b         = alu_b_s;
    assign alu_op        = ex_r.alu_op;
    assign ex_valid      = ex_r.valid;
    assign ex_reg_write  = ex_r.reg_write;
    assign ex_mem_read   = ex_r.mem_read;
    assign ex_mem_write  = ex_r.mem_write;
    assign ex_mem_to_reg = ex_r.mem_to_reg;
    assign ex_dst        = ex_r.dst;
    assign ex_store_data = fwd_rt_s;
    assign ex_pc         = ex_r.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios for reset, extension, forwarding, load-use and
// flush/hold, followed by randomized cycles checked against a behavioural
// model of the instruction occupying EX.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_src_a;
    logic [1:0]  id_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        hold, flush;
    logic        mem_reg_write;
    logic [4:0]  mem_dst;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;
    logic        load_use_stall;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_dst;
    logic [31:0] ex_store_data, ex_pc;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .hold(hold), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .load_use_stall(load_use_stall),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_dst(ex_dst), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction sitting in EX.
    bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_sa;
    logic [4:0]  m_dst, m_rs, m_rt, m_sh;
    logic [31:0] m_pc, m_rsd, m_rtd;
    logic [15:0] m_imm;
    logic [3:0]  m_op;
    logic [1:0]  m_sb;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_pc = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_imm = 16'h0; id_shamt = 5'd0;
        id_alu_op = 4'd0; id_src_a = 1'b0; id_src_b = 2'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        hold = 1'b0; flush = 1'b0;
        mem_reg_write = 1'b0; mem_dst = 5'd0; mem_result = 32'h0;
        wb_reg_write = 1'b0; wb_dst = 5'd0; wb_result = 32'h0;
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_sa = 1'b0;
        m_dst = 5'd0; m_rs = 5'd0; m_rt = 5'd0; m_sh = 5'd0;
        m_pc = 32'h0; m_rsd = 32'h0; m_rtd = 32'h0; m_imm = 16'h0; m_op = 4'd0; m_sb = 2'd0;
    endtask

    function automatic logic [31:0] fwd_of(input logic [4:0] idx, input logic [31:0] regd);
        if (idx != 5'd0 && mem_reg_write && mem_dst == idx) return mem_result;
        if (idx != 5'd0 && wb_reg_write && wb_dst == idx) return wb_result;
        return regd;
    endfunction

    function automatic logic [31:0] exp_a();
        if (m_sa) return {27'd0, m_sh};
        return fwd_of(m_rs, m_rsd);
    endfunction

    function automatic logic [31:0] exp_b();
        logic [31:0] v;
        case (m_sb)
            2'd1:    v = {{16{m_imm[15]}}, m_imm};
            2'd2:    v = {16'h0000, m_imm};
            default: v = fwd_of(m_rt, m_rtd);
        endcase
        return v;
    endfunction

    function automatic logic exp_stall();
        logic rt_used;
        rt_used = (id_src_b == 2'd0) || id_mem_write;
        if (flush || !m_valid || !m_mr || m_dst == 5'd0 || !id_valid) return 1'b0;
        return (m_dst == id_rs) || (m_dst == id_rt && rt_used);
    endfunction

    task automatic model_edge(input logic st);
        if (flush || (!hold && st)) begin
            model_clear();
        end else if (!hold) begin
            m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read;
            m_mw = id_mem_write; m_m2r = id_mem_to_reg; m_dst = id_rd;
            m_rs = id_rs; m_rt = id_rt; m_pc = id_pc; m_rsd = id_rs_data; m_rtd = id_rt_data;
            m_imm = id_imm; m_sh = id_shamt; m_op = id_alu_op; m_sa = id_src_a; m_sb = id_src_b;
        end
    endtask

    task automatic drive_random();
        id_valid = ($urandom_range(0, 9) < 8);
        id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_imm = 16'($urandom); id_shamt = 5'($urandom); id_alu_op = 4'($urandom);
        id_src_a = 1'($urandom); id_src_b = 2'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = ($urandom_range(0, 3) == 0); id_mem_to_reg = 1'($urandom);
        hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
        mem_reg_write = 1'($urandom); mem_dst = 5'($urandom_range(0, 3)); mem_result = $urandom;
        wb_reg_write = 1'($urandom); wb_dst = 5'($urandom_range(0, 3)); wb_result = $urandom;
    endtask

    task automatic check_model();
        check_eq("rnd_stall", 64'(load_use_stall), 64'(exp_stall()));
        check_eq("rnd_valid", 64'(ex_valid), 64'(m_valid));
        check_eq("rnd_ctrl", {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                 {60'd0, m_rw, m_mr, m_mw, m_m2r});
        if (m_valid) begin
            check_eq("rnd_alu_a", 64'(alu_a), 64'(exp_a()));
            check_eq("rnd_alu_b", 64'(alu_b), 64'(exp_b()));
            check_eq("rnd_store", 64'(ex_store_data), 64'(fwd_of(m_rt, m_rtd)));
            check_eq("rnd_op", 64'(alu_op), 64'(m_op));
            check_eq("rnd_dst", 64'(ex_dst), 64'(m_dst));
            check_eq("rnd_pc", 64'(ex_pc), 64'(m_pc));
        end
    endtask

    initial begin
        logic st;
        rst_n = 1'b0;
        set_idle();

        // Reset state
        #8;
        check_eq("rst_valid", 64'(ex_valid), 64'd0);
        check_eq("rst_op", 64'(alu_op), 64'd0);
        check_eq("rst_dst", 64'(ex_dst), 64'd0);
        check_eq("rst_pc", 64'(ex_pc), 64'd0);
        check_eq("rst_alu_a", 64'(alu_a), 64'd0);
        check_eq("rst_store", 64'(ex_store_data), 64'd0);
        #4 rst_n = 1'b1;
        step_clk();

        // Sign / zero extension and shamt
        id_valid = 1'b1; id_reg_write = 1'b1; id_imm = 16'h8001; id_src_b = 2'd1;
        id_src_a = 1'b1; id_shamt = 5'd5;
        step_clk();
        check_eq("sext_b", 64'(alu_b), 64'hFFFF8001);
        check_eq("shamt_a", 64'(alu_a), 64'd5);
        id_src_b = 2'd2;
        step_clk();
        check_eq("zext_b", 64'(alu_b), 64'h00008001);

        // Forwarding priority
        id_src_a = 1'b0; id_src_b = 2'd0; id_rs = 5'd3; id_rs_data = 32'h1111;
        step_clk();
        mem_reg_write = 1'b1; mem_dst = 5'd3; mem_result = 32'hAAAA;
        wb_reg_write = 1'b1; wb_dst = 5'd3; wb_result = 32'hBBBB;
        #1 check_eq("fwd_mem", 64'(alu_a), 64'hAAAA);
        mem_reg_write = 1'b0;
        #1 check_eq("fwd_wb", 64'(alu_a), 64'hBBBB);
        wb_reg_write = 1'b0;
        #1 check_eq("fwd_none", 64'(alu_a), 64'h1111);

        // Register 0 never forwards
        id_rs = 5'd0; id_rs_data = 32'h0;
        step_clk();
        mem_reg_write = 1'b1; mem_dst = 5'd0; mem_result = 32'h1234;
        #1 check_eq("reg0_a", 64'(alu_a), 64'd0);
        mem_reg_write = 1'b0;

        // Load-use: lw r8 then add using rt=r8
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
        id_rd = 5'd8; id_src_b = 2'd1;
        step_clk();
        id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_rd = 5'd9; id_src_b = 2'd0;
        id_rs = 5'd1; id_rs_data = 32'h10; id_rt = 5'd8; id_rt_data = 32'h5555;
        #1 check_eq("lu_stall", 64'(load_use_stall), 64'd1);
        step_clk();
        check_eq("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check_eq("lu_bubble_ctrl", {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 64'd0);
        check_eq("lu_stall_clear", 64'(load_use_stall), 64'd0);
        mem_reg_write = 1'b1; mem_dst = 5'd8; mem_result = 32'hC0DE;
        step_clk();
        check_eq("lu_add_valid", 64'(ex_valid), 64'd1);
        check_eq("lu_add_dst", 64'(ex_dst), 64'd9);
        check_eq("lu_add_fwd", 64'(alu_b), 64'hC0DE);
        mem_reg_write = 1'b0;

        // Flush wins over hold
        flush = 1'b1; hold = 1'b1;
        step_clk();
        check_eq("flush_hold", 64'(ex_valid), 64'd0);
        flush = 1'b0; hold = 1'b0;

        // Hold keeps everything for 3 cycles
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_rs = 5'd2; id_rs_data = 32'h2222;
        id_rt = 5'd4; id_rt_data = 32'h4444; id_alu_op = 4'd3; id_rd = 5'd6; id_pc = 32'h100;
        step_clk();
        hold = 1'b1;
        id_pc = 32'h200; id_rs_data = 32'h9999; id_rt_data = 32'h8888; id_alu_op = 4'd7;
        id_rd = 5'd11; id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check_eq("hold_valid", 64'(ex_valid), 64'd1);
            check_eq("hold_pc", 64'(ex_pc), 64'h100);
            check_eq("hold_a", 64'(alu_a), 64'h2222);
            check_eq("hold_b", 64'(alu_b), 64'h4444);
            check_eq("hold_op", 64'(alu_op), 64'd3);
            check_eq("hold_dst", 64'(ex_dst), 64'd6);
        end

        // Mid-cycle asynchronous reset
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(ex_valid), 64'd0);
        check_eq("arst_rw", 64'(ex_reg_write), 64'd0);
        check_eq("arst_op", 64'(alu_op), 64'd0);
        #2 rst_n = 1'b1;
        set_idle();
        model_clear();
        step_clk();

        // Randomized cycles against the model
        for (int n = 0; n < 400; n++) begin
            drive_random();
            #4;
            check_model();
            st = exp_stall();
            @(posedge clk);
            model_edge(st);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
